snes_poll_scheduler: RTL and testbench

Sequences the serial read of both players' SNES/NES pads once per video frame. Driven by a frame-start pulse derived from the XYCounter vertical sync, it generates the latch and shift-clock waveforms for each player's controller port in lockstep, deserialises the 16 button bits, and publishes both button words atomically with a one-cycle valid strobe for the Player logic. Ports whose player has not selected the SNES source are held idle.

---
 rtl/snes_poll_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_snes_poll_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/snes_poll_scheduler.sv
// rtl/snes_poll_scheduler.sv - once-per-frame dual SNES/NES pad poll sequencer
module snes_poll_scheduler #(
    parameter int          CLK_DIV     = 300,
    parameter int          NUM_BITS    = 16,
    parameter logic [1:0]  SNES_CHOICE = 2'b10
) (
    input  logic                Clock,
    input  logic                NReset,
    input  logic                Frame_Start,
    input  logic [1:0]          Choice_Player1,
    input  logic [1:0]          Choice_Player2,
    input  logic                SNESData1,
    input  logic                SNESData2,
    output logic                NStrobe_Latch1,
    output logic                NStrobe_Latch2,
    output logic                NShift_Clock1,
    output logic                NShift_Clock2,
    output logic [NUM_BITS-1:0] Buttons1,
    output logic [NUM_BITS-1:0] Buttons2,
    output logic                Buttons_Valid,
    output logic                Busy,
    output logic                Overrun
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                en1_q, en1_d, en2_q, en2_d;
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BITS-1:0] shreg1_q, shreg1_d, shreg2_q, shreg2_d;
    logic [NUM_BITS-1:0] buttons1_q, buttons1_d, buttons2_q, buttons2_d;
    logic                latch1_q, latch1_d, latch2_q, latch2_d;
    logic                sclk1_q, sclk1_d, sclk2_q, sclk2_d;
    logic                valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;

    // Next-state, phase timing and registered-output computation for the poll sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        en1_d      = en1_q;
        en2_d      = en2_q;
        sync1_d    = {sync1_q[0], SNESData1};
        sync2_d    = {sync2_q[0], SNESData2};
        shreg1_d   = shreg1_q;
        shreg2_d   = shreg2_q;
        buttons1_d = buttons1_q;
        buttons2_d = buttons2_q;
        latch1_d   = latch1_q;
        latch2_d   = latch2_q;
        sclk1_d    = sclk1_q;
        sclk2_d    = sclk2_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        // Any request that arrives outside IDLE is dropped and flagged
        overrun_d  = Frame_Start && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Frame_Start) begin
                    en1_d    = (Choice_Player1 == SNES_CHOICE);
                    en2_d    = (Choice_Player2 == SNES_CHOICE);
                    idx_d    = '0;
                    latch1_d = en1_d;
                    latch2_d = en2_d;
                    busy_d   = 1'b1;
                    state_d  = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d    = '0;
                    latch1_d = 1'b0;
                    latch2_d = 1'b0;
                    sclk1_d  = ~en1_q;
                    sclk2_d  = ~en2_q;
                    state_d  = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == PHASE_LAST) begin
                    // Sample at the end of the low phase, when the pad data has long settled
                    cnt_d           = '0;
                    shreg1_d[idx_q] = ~sync1_q[1];
                    shreg2_d[idx_q] = ~sync2_q[1];
                    sclk1_d         = 1'b1;
                    sclk2_d         = 1'b1;
                    state_d         = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        // Both words publish together so the consumer never sees a half-updated pair
                        buttons1_d = en1_q ? shreg1_q : '0;
                        buttons2_d = en2_q ? shreg2_q : '0;
                        valid_d    = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        sclk1_d = ~en1_q;
                        sclk2_d = ~en2_q;
                        state_d = S_LOW;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any poll immediately
    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            shreg1_q   <= '0;
            shreg2_q   <= '0;
            buttons1_q <= '0;
            buttons2_q <= '0;
            latch1_q   <= 1'b0;
            latch2_q   <= 1'b0;
            sclk1_q    <= 1'b1;
            sclk2_q    <= 1'b1;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            en1_q      <= en1_d;
            en2_q      <= en2_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            shreg1_q   <= shreg1_d;
            shreg2_q   <= shreg2_d;
            buttons1_q <= buttons1_d;
            buttons2_q <= buttons2_d;
            latch1_q   <= latch1_d;
            latch2_q   <= latch2_d;
            sclk1_q    <= sclk1_d;
            sclk2_q    <= sclk2_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign NStrobe_Latch1 = latch1_q;
    assign NStrobe_Latch2 = latch2_q;
    assign NShift_Clock1  = sclk1_q;
    assign NShift_Clock2  = sclk2_q;
    assign Buttons1       = buttons1_q;
    assign Buttons2       = buttons2_q;
    assign Buttons_Valid  = valid_q;
    assign Busy           = busy_q;
    assign Overrun        = overrun_q;

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// tb/tb_snes_poll_scheduler.sv - directed vector bench for snes_poll_scheduler
module tb_snes_poll_scheduler;

    logic        Clock = 1'b0;
    logic        NReset;
    logic        Frame_Start;
    logic [1:0]  Choice_Player1, Choice_Player2;
    logic        SNESData1, SNESData2;
    logic        NStrobe_Latch1, NStrobe_Latch2, NShift_Clock1, NShift_Clock2;
    logic [15:0] Buttons1, Buttons2;
    logic        Buttons_Valid, Busy, Overrun;

    int n_chk = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    snes_poll_scheduler #(.CLK_DIV(4), .NUM_BITS(16), .SNES_CHOICE(2'b10)) dut (
        .Clock(Clock), .NReset(NReset), .Frame_Start(Frame_Start),
        .Choice_Player1(Choice_Player1), .Choice_Player2(Choice_Player2),
        .SNESData1(SNESData1), .SNESData2(SNESData2),
        .NStrobe_Latch1(NStrobe_Latch1), .NStrobe_Latch2(NStrobe_Latch2),
        .NShift_Clock1(NShift_Clock1), .NShift_Clock2(NShift_Clock2),
        .Buttons1(Buttons1), .Buttons2(Buttons2),
        .Buttons_Valid(Buttons_Valid), .Busy(Busy), .Overrun(Overrun)
    );

    // Pad models: latch reloads bit 0, each shift-clock rising edge advances one bit
    logic [15:0] pw1, pw2;
    logic [4:0]  pi1, pi2;
    logic        hold2;

    always @(posedge NShift_Clock1 or posedge NStrobe_Latch1)
        if (NStrobe_Latch1) pi1 <= 5'd0;
        else if (!pi1[4])   pi1 <= pi1 + 5'd1;

    always @(posedge NShift_Clock2 or posedge NStrobe_Latch2)
        if (NStrobe_Latch2) pi2 <= 5'd0;
        else if (!pi2[4])   pi2 <= pi2 + 5'd1;

    assign SNESData1 = pi1[4] ? 1'b1 : ~pw1[pi1[3:0]];
    assign SNESData2 = hold2 ? 1'b0 : (pi2[4] ? 1'b1 : ~pw2[pi2[3:0]]);

    typedef struct {
        logic [1:0]  c1, c2;
        logic [15:0] p1, p2;
        logic        hold2;
        logic        en1, en2;
        logic [15:0] e1, e2;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] prev1 = 16'h0;
    logic [15:0] prev2 = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full poll with Frame_Start at cycle 0; optional overrun, Choice-change and reset events
    task automatic run_poll(input vec_t v, input bit ovr, input bit chg, input bit rst, input string tag);
        int  bad_l1 = 0, bad_l2 = 0, bad_c1 = 0, bad_c2 = 0, bad_v = 0, bad_b = 0, bad_o = 0;
        bit  in_rst, lat_e, low;
        Choice_Player1 = v.c1;
        Choice_Player2 = v.c2;
        pw1 = v.p1;
        pw2 = v.p2;
        hold2 = v.hold2;
        for (int cyc = 0; cyc <= 141; cyc++) begin
            @(posedge Clock); #1;
            Frame_Start = (cyc == 0) || (ovr && (cyc == 50 || cyc == 137 || cyc == 138));
            if (chg && cyc == 20) Choice_Player1 = 2'b00;
            if (rst && cyc == 70) NReset = 1'b0;
            if (rst && cyc == 75) NReset = 1'b1;
            @(negedge Clock);
            in_rst = rst && cyc >= 70;
            lat_e  = !in_rst && ((cyc >= 1 && cyc <= 8) || (ovr && cyc >= 139));
            low    = !in_rst && cyc >= 9 && cyc <= 136 && ((cyc - 9) % 8) < 4;
            if (NStrobe_Latch1 !== (lat_e && v.en1)) bad_l1++;
            if (NStrobe_Latch2 !== (lat_e && v.en2)) bad_l2++;
            if (NShift_Clock1 !== !(low && v.en1)) bad_c1++;
            if (NShift_Clock2 !== !(low && v.en2)) bad_c2++;
            if (Buttons_Valid !== (!in_rst && cyc == 137)) bad_v++;
            if (Busy !== (!in_rst && ((cyc >= 1 && cyc <= 137) || (ovr && cyc >= 139)))) bad_b++;
            if (Overrun !== (ovr && (cyc == 51 || cyc == 138))) bad_o++;
            if (cyc == 136) begin
                chk({tag, " buttons1_hold"}, 32'(Buttons1), 32'(in_rst ? 16'h0 : prev1));
                chk({tag, " buttons2_hold"}, 32'(Buttons2), 32'(in_rst ? 16'h0 : prev2));
            end
            if (cyc == 137) begin
                chk({tag, " buttons1"}, 32'(Buttons1), 32'(in_rst ? 16'h0 : v.e1));
                chk({tag, " buttons2"}, 32'(Buttons2), 32'(in_rst ? 16'h0 : v.e2));
            end
        end
        Frame_Start = 1'b0;
        chk({tag, " latch1_wave_errs"}, 32'(bad_l1), 32'd0);
        chk({tag, " latch2_wave_errs"}, 32'(bad_l2), 32'd0);
        chk({tag, " sclk1_wave_errs"},  32'(bad_c1), 32'd0);
        chk({tag, " sclk2_wave_errs"},  32'(bad_c2), 32'd0);
        chk({tag, " valid_errs"},       32'(bad_v),  32'd0);
        chk({tag, " busy_errs"},        32'(bad_b),  32'd0);
        chk({tag, " overrun_errs"},     32'(bad_o),  32'd0);
        prev1 = rst ? 16'h0 : v.e1;
        prev2 = rst ? 16'h0 : v.e2;
        for (int k = 0; k < 300 && Busy; k++) @(negedge Clock);
        chk({tag, " drain_busy"}, 32'(Busy), 32'd0);
        if (ovr) begin
            chk({tag, " second_poll_b1"}, 32'(Buttons1), 32'(v.e1));
            chk({tag, " second_poll_b2"}, 32'(Buttons2), 32'(v.e2));
        end
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        //          c1     c2     p1        p2        hold2 en1   en2   e1        e2
        vecs[0] = '{2'b10, 2'b10, 16'h0F0A, 16'hA5C3, 1'b0, 1'b1, 1'b1, 16'h0F0A, 16'hA5C3};
        vecs[1] = '{2'b10, 2'b00, 16'h1234, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000};
        vecs[2] = '{2'b00, 2'b10, 16'hFFFF, 16'h8001, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8001};
        vecs[3] = '{2'b01, 2'b11, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{2'b10, 2'b10, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
        vecs[5] = '{2'b10, 2'b10, 16'h5A5A, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h5A5A, 16'h0001};
        vecs[6] = '{2'b00, 2'b10, 16'h5A5A, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001};
        vecs[7] = '{2'b10, 2'b10, 16'h6C39, 16'h9E01, 1'b0, 1'b1, 1'b1, 16'h6C39, 16'h9E01};

        NReset = 1'b0;
        Frame_Start = 1'b0;
        Choice_Player1 = 2'b10;
        Choice_Player2 = 2'b10;
        pw1 = 16'h0;
        pw2 = 16'h0;
        hold2 = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset_in latch", 32'({NStrobe_Latch1, NStrobe_Latch2}), 32'd0);
        chk("reset_in sclk",  32'({NShift_Clock1, NShift_Clock2}), 32'd3);
        chk("reset_in flags", 32'({Buttons_Valid, Busy, Overrun}), 32'd0);
        @(posedge Clock); #1;
        NReset = 1'b1;
        repeat (2) @(negedge Clock);
        chk("reset_out buttons", {Buttons1, Buttons2}, 32'd0);
        chk("reset_out pins", 32'({NStrobe_Latch1, NStrobe_Latch2, NShift_Clock1, NShift_Clock2}), 32'h3);
        chk("reset_out flags", 32'({Buttons_Valid, Busy, Overrun}), 32'd0);

        for (int i = 0; i < 5; i++) run_poll(vecs[i], 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));

        run_poll(vecs[0], 1'b1, 1'b0, 1'b0, "overrun");
        run_poll(vecs[5], 1'b0, 1'b1, 1'b0, "choice_chg");
        run_poll(vecs[6], 1'b0, 1'b0, 1'b0, "after_chg");
        run_poll(vecs[7], 1'b0, 1'b0, 1'b1, "reset_mid");
        run_poll(vecs[7], 1'b0, 1'b0, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
